// File: rtl/push_cnt_pkg.sv
// Shared constants and helpers for the push-driven one-hot ring counter.
package push_cnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_IN_W      = 8;
  localparam int unsigned DEF_DB_CYCLES = 4;

  // True when exactly one bit of the (zero-extended) vector is set.
  function automatic bit onehot_ok(input logic [63:0] vec);
    return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
  endfunction

  // Binary position of the set bit; only meaningful for a one-hot input.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] vec);
    logic [5:0] res;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (vec[i]) res = res | 6'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/push_sync_edge.sv
// Push input front end: 2-flop synchroniser per line, OR-reduction, optional
// debounce filter (PUSH_DEBOUNCE_EN) and rising-edge detect to a 1-cycle pulse.
module push_sync_edge
  import push_cnt_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] inpp,
  output logic            push
);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("push_sync_edge: DB_CYCLES must be in 1..255");
  end

  logic [IN_W-1:0] sync1_q, sync2_q;
  logic            any;
  logic            level;
  logic            level_q;

  // Two-stage synchroniser for the asynchronous button lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= inpp;
      sync2_q <= sync1_q;
    end
  end

  assign any = |sync2_q;

`ifdef PUSH_DEBOUNCE_EN
  logic       filt_q;
  logic [7:0] cnt_q;

  // Filtered level follows the raw level only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (any != filt_q) begin
      if (cnt_q == 8'(DB_CYCLES - 1)) begin
        filt_q <= any;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = any;
`endif

  // Delayed copy of the level for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign push = level & ~level_q;

endmodule

// File: rtl/push_ring_cnt.sv
// One-hot ring counter stepped by push events, with direction select, binary
// index, wrap pulse and sticky illegal-state detection with recovery.
// Optional debounce in the input path is enabled by defining PUSH_DEBOUNCE_EN.
module push_ring_cnt
  import push_cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             register,
  input  logic             dir,
  input  logic [IN_W-1:0]  inpp,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("push_ring_cnt: WIDTH must be in 2..64");
  end

  logic             push;
  logic [WIDTH-1:0] out_q, out_step;
  logic [IDX_W-1:0] idx_q, idx_step;
  logic             wrap_q, wrap_step;
  logic             err_q;
  logic             legal;

  push_sync_edge #(
    .IN_W      (IN_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_push_sync_edge (
    .clock (clock),
    .reset (reset),
    .inpp  (inpp),
    .push  (push)
  );

  assign legal = onehot_ok(64'(out_q));

  // Candidate next position, its index and whether the step crosses the ring seam.
  always_comb begin
    if (dir == DIR_UP) begin
      out_step  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      wrap_step = out_q[WIDTH-1];
    end else begin
      out_step  = {out_q[0], out_q[WIDTH-1:1]};
      wrap_step = out_q[0];
    end
    idx_step = IDX_W'(onehot_to_idx(64'(out_step)));
  end

  // Ring state: reset, then recovery (swallows any coincident push), then stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q  <= WIDTH'(1);
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (!legal) begin
      out_q  <= WIDTH'(1);
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b1;
    end else if (push && register) begin
      out_q  <= out_step;
      idx_q  <= idx_step;
      wrap_q <= wrap_step;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_push_ring_cnt.sv
// Directed self-checking bench for push_ring_cnt (WIDTH = IN_W = 8, DB_CYCLES = 4).
module tb_push_ring_cnt;

`ifdef PUSH_DEBOUNCE_EN
  localparam int LAT  = 6;
  localparam int HOLD = 10;
  localparam int GAP  = 10;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 6;
  localparam int GAP  = 6;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       register;
  logic       dir;
  logic [7:0] inpp;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int w0;
  logic [7:0] exp_out;

  push_ring_cnt #(
    .WIDTH     (8),
    .IN_W      (8),
    .DB_CYCLES (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .register (register),
    .dir      (dir),
    .inpp     (inpp),
    .out      (out),
    .idx      (idx),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clock = ~clock;

  // Counts cycles with wrap high, sampled away from the active edge.
  always @(negedge clock) begin
    if (wrap === 1'b1) wrap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    inpp  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clock);
    inpp = v;
    repeat (HOLD) @(negedge clock);
    inpp = 8'h00;
    repeat (GAP) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    register = 1'b1;
    dir      = 1'b0;
    inpp     = 8'h00;

    // Reset state
    do_reset();
    check("reset_out", 32'(out), 32'h01);
    check("reset_idx", 32'(idx), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    // First push with exact latency
    w0 = wrap_cnt;
    inpp = 8'h01;
    repeat (LAT) @(posedge clock);
    #1 check("lat_before", 32'(out), 32'h01);
    @(posedge clock);
    #1 check("lat_out", 32'(out), 32'h02);
    check("lat_idx", 32'(idx), 32'h1);
    @(negedge clock);
    inpp = 8'h00;
    repeat (GAP + HOLD) @(negedge clock);

    // Eight more pushes: 04 .. 80, 01
    for (int i = 2; i <= 9; i++) begin
      push(8'h01);
      exp_out = 8'h01 << (i % 8);
      check("up_out", 32'(out), 32'(exp_out));
      check("up_idx", 32'(idx), 32'(i % 8));
    end
    check("up_wrap_count", 32'(wrap_cnt - w0), 32'd1);
    check("up_err", 32'(err), 32'h0);

    // Down direction from reset wraps 01 -> 80
    dir = 1'b1;
    do_reset();
    w0 = wrap_cnt;
    push(8'h04);
    check("down_out", 32'(out), 32'h80);
    check("down_idx", 32'(idx), 32'h7);
    check("down_wrap_count", 32'(wrap_cnt - w0), 32'd1);
    push(8'h04);
    check("down_out2", 32'(out), 32'h40);
    check("down_idx2", 32'(idx), 32'h6);
    dir = 1'b0;

    // Event while register low is dropped, not queued
    do_reset();
    register = 1'b0;
    inpp = 8'h01;
    repeat (HOLD + GAP) @(negedge clock);
    register = 1'b1;
    repeat (10) @(negedge clock);
    check("reg_drop_held", 32'(out), 32'h01);
    inpp = 8'h00;
    repeat (GAP) @(negedge clock);
    check("reg_drop_after", 32'(out), 32'h01);
    push(8'h20);
    check("reg_enabled", 32'(out), 32'h02);

    // Second line rising while first is held: one step only
    @(negedge clock);
    inpp = 8'h01;
    repeat (HOLD) @(negedge clock);
    inpp = 8'h03;
    repeat (HOLD) @(negedge clock);
    inpp = 8'h00;
    repeat (GAP) @(negedge clock);
    check("overlap_out", 32'(out), 32'h04);
    check("overlap_idx", 32'(idx), 32'h2);

    // Illegal state recovery and sticky err
    w0 = wrap_cnt;
    @(negedge clock);
    force dut.out_q = 8'h12;
    @(negedge clock);
    release dut.out_q;
    @(posedge clock);
    #1 check("recover_out", 32'(out), 32'h01);
    check("recover_idx", 32'(idx), 32'h0);
    check("recover_err", 32'(err), 32'h1);
    check("recover_wrap_count", 32'(wrap_cnt - w0), 32'd0);
    for (int i = 0; i < 10; i++) push(8'h10);
    check("sticky_err", 32'(err), 32'h1);
    check("sticky_out", 32'(out), 32'h04);
    do_reset();
    check("err_cleared", 32'(err), 32'h0);
    check("err_reset_out", 32'(out), 32'h01);

`ifdef PUSH_DEBOUNCE_EN
    // Short pulse filtered out
    @(negedge clock);
    inpp = 8'h01;
    repeat (3) @(negedge clock);
    inpp = 8'h00;
    repeat (20) @(negedge clock);
    check("db_short", 32'(out), 32'h01);

    // 6-cycle pulse: one step, 6 edges after first sampling
    inpp = 8'h01;
    repeat (6) @(negedge clock);
    inpp = 8'h00;
    check("db_long_before", 32'(out), 32'h01);
    @(posedge clock);
    #1 check("db_long_out", 32'(out), 32'h02);
    repeat (20) @(negedge clock);
    check("db_long_single", 32'(out), 32'h02);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
